// File: rtl/cp_dmem_arbiter.sv
// cp_dmem_arbiter: shares the CP data memory port between the core load/store
// path and a DMA/host port. The core has default priority. A DMA that is blocked
// for MAX_WAIT consecutive cycles gets a priority burst of up to BURST_LEN
// beats, and the core is stalled during that burst.
// Ports:
//   iClk, iReset            clock, synchronous active-high reset
//   iCore_*                 core request (write/read enable, lanes, address, data)
//   oCore_Stall/Load_Data   core stall and load data
//   iDMA_* / oDMA_*         DMA request, grant and read return
//   oDMEM_* / iDMEM_*       DMEM macro port (read data arrives 1 cycle later)
//   oPerf_*                 perf counters, only when CP_DMEM_ARB_PERF_EN is
//                           defined (otherwise tied to 0)
module cp_dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iCore_Write_Enable,
  input  logic                    iCore_Read_Enable,
  input  logic [DATA_WIDTH/8-1:0] iCore_Byte_Select,
  input  logic [ADDR_WIDTH-1:0]   iCore_Address,
  input  logic [DATA_WIDTH-1:0]   iCore_Store_Data,
  output logic                    oCore_Stall,
  output logic [DATA_WIDTH-1:0]   oCore_Load_Data,
  input  logic                    iDMA_Req,
  input  logic                    iDMA_Write,
  input  logic [ADDR_WIDTH-1:0]   iDMA_Address,
  input  logic [DATA_WIDTH-1:0]   iDMA_Store_Data,
  output logic                    oDMA_Grant,
  output logic                    oDMA_Rvalid,
  output logic [DATA_WIDTH-1:0]   oDMA_Rdata,
  output logic                    oDMEM_Write_Enable,
  output logic                    oDMEM_Read_Enable,
  output logic [DATA_WIDTH/8-1:0] oDMEM_Byte_Select,
  output logic [ADDR_WIDTH-1:0]   oDMEM_Address,
  output logic [DATA_WIDTH-1:0]   oDMEM_Store_Data,
  input  logic [DATA_WIDTH-1:0]   iDMEM_Load_Data,
  output logic [31:0]             oPerf_Stall_Count,
  output logic [31:0]             oPerf_DMA_Beats
);

  localparam int unsigned BS_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {S_CORE = 1'b0, S_DMA = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic               rd_dma_q, rd_dma_d;
  logic               creq;
  logic               dma_sel;

  assign creq = iCore_Write_Enable | iCore_Read_Enable;

  // Arbitration, starvation escalation and burst length tracking
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    beat_d      = beat_q;
    dma_sel     = 1'b0;
    oCore_Stall = 1'b0;
    case (state_q)
      S_CORE: begin
        dma_sel = !creq && iDMA_Req;
        if (iDMA_Req && !dma_sel) begin
          if (wait_q == CNT_W'(MAX_WAIT - 1)) begin
            state_d = S_DMA;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end else begin
          wait_d = '0;
        end
      end
      S_DMA: begin
        wait_d = '0;
        if (iDMA_Req) begin
          dma_sel     = 1'b1;
          oCore_Stall = creq;
          if (beat_q == CNT_W'(BURST_LEN - 1)) begin
            state_d = S_CORE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end else begin
          // DMA went quiet: core is served normally and the burst ends
          state_d = S_CORE;
          beat_d  = '0;
        end
      end
      default: state_d = S_CORE;
    endcase
    if (iReset) begin
      dma_sel     = 1'b0;
      oCore_Stall = 1'b0;
    end
  end

  // DMEM port mux; idle cycles present the core fields with enables low
  always_comb begin
    oDMA_Grant         = dma_sel;
    oDMEM_Write_Enable = iCore_Write_Enable && !iReset && !oCore_Stall;
    oDMEM_Read_Enable  = iCore_Read_Enable && !iReset && !oCore_Stall;
    oDMEM_Byte_Select  = iCore_Byte_Select;
    oDMEM_Address      = iCore_Address;
    oDMEM_Store_Data   = iCore_Store_Data;
    if (dma_sel) begin
      oDMEM_Write_Enable = iDMA_Write;
      oDMEM_Read_Enable  = !iDMA_Write;
      oDMEM_Byte_Select  = {BS_W{1'b1}};
      oDMEM_Address      = iDMA_Address;
      oDMEM_Store_Data   = iDMA_Store_Data;
    end
  end

  assign rd_dma_d = dma_sel && !iDMA_Write;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= S_CORE;
      wait_q   <= '0;
      beat_q   <= '0;
      rd_dma_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      rd_dma_q <= rd_dma_d;
    end
  end

  // Read data is shared; the owner flag doubles as the DMA valid pulse
  assign oDMA_Rvalid     = rd_dma_q;
  assign oDMA_Rdata      = iDMEM_Load_Data;
  assign oCore_Load_Data = iDMEM_Load_Data;

`ifdef CP_DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] beats_cnt_q;

  // Saturating event counters
  always_ff @(posedge iClk) begin
    if (iReset) begin
      stall_cnt_q <= '0;
      beats_cnt_q <= '0;
    end else begin
      if (oCore_Stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (oDMA_Grant && (beats_cnt_q != '1)) beats_cnt_q <= beats_cnt_q + 32'd1;
    end
  end

  assign oPerf_Stall_Count = stall_cnt_q;
  assign oPerf_DMA_Beats   = beats_cnt_q;
`else
  assign oPerf_Stall_Count = '0;
  assign oPerf_DMA_Beats   = '0;
`endif

endmodule

// File: tb/tb_cp_dmem_arbiter.sv
// Self-checking bench for cp_dmem_arbiter (default parameters: 32-bit,
// MAX_WAIT=8, BURST_LEN=4). Includes a behavioural DMEM with 1-cycle read latency.
module tb_cp_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_we, c_re;
  logic [3:0]  c_bs;
  logic [31:0] c_addr, c_wd;
  logic        stall;
  logic [31:0] core_ld;
  logic        d_req, d_wr;
  logic [31:0] d_addr, d_wd;
  logic        grant, rvalid;
  logic [31:0] rdata;
  logic        m_we, m_re;
  logic [3:0]  m_bs;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [31:0] perf_stall, perf_beats;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sbq[$];
  logic [31:0] mem [256];

  cp_dmem_arbiter dut (
    .iClk(clk), .iReset(rst),
    .iCore_Write_Enable(c_we), .iCore_Read_Enable(c_re),
    .iCore_Byte_Select(c_bs), .iCore_Address(c_addr), .iCore_Store_Data(c_wd),
    .oCore_Stall(stall), .oCore_Load_Data(core_ld),
    .iDMA_Req(d_req), .iDMA_Write(d_wr), .iDMA_Address(d_addr),
    .iDMA_Store_Data(d_wd), .oDMA_Grant(grant), .oDMA_Rvalid(rvalid),
    .oDMA_Rdata(rdata),
    .oDMEM_Write_Enable(m_we), .oDMEM_Read_Enable(m_re),
    .oDMEM_Byte_Select(m_bs), .oDMEM_Address(m_addr),
    .oDMEM_Store_Data(m_wd), .iDMEM_Load_Data(m_rd),
    .oPerf_Stall_Count(perf_stall), .oPerf_DMA_Beats(perf_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // DMEM model: preloaded with pat() during reset, 1-cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(32'(i * 4));
    end else begin
      if (m_we)
        for (int b = 0; b < 4; b++)
          if (m_bs[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wd[8*b +: 8];
      if (m_re) m_rd <= mem[m_addr[9:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check 1 time unit later
  task automatic step(input logic rst_v, input logic cwe, input logic cre,
                      input logic [3:0] cbs, input logic [31:0] caddr,
                      input logic [31:0] cwd, input logic dreq, input logic dwr,
                      input logic [31:0] daddr, input logic [31:0] dwd,
                      input logic eg, input logic es, input string nm);
    logic [31:0] exp_rd;
    @(negedge clk);
    rst = rst_v; c_we = cwe; c_re = cre; c_bs = cbs; c_addr = caddr; c_wd = cwd;
    d_req = dreq; d_wr = dwr; d_addr = daddr; d_wd = dwd;
    #1;
    if (sbq.size() > 0) begin
      exp_rd = sbq.pop_front();
      chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
      chk({nm, "_rdata"}, rdata, exp_rd);
      chk({nm, "_core_ld"}, core_ld, exp_rd);
    end else begin
      chk({nm, "_rvalid"}, 32'(rvalid), 32'd0);
    end
    chk({nm, "_grant"}, 32'(grant), 32'(eg));
    chk({nm, "_stall"}, 32'(stall), 32'(es));
    chk({nm, "_we"}, 32'(m_we), rst_v ? 32'd0 : (eg ? 32'(dwr) : (es ? 32'd0 : 32'(cwe))));
    chk({nm, "_re"}, 32'(m_re), rst_v ? 32'd0 : (eg ? 32'(!dwr) : (es ? 32'd0 : 32'(cre))));
    chk({nm, "_addr"}, m_addr, eg ? daddr : caddr);
    chk({nm, "_bs"}, 32'(m_bs), eg ? 32'hF : 32'(cbs));
    chk({nm, "_wd"}, m_wd, eg ? dwd : cwd);
    if (eg && !dwr) sbq.push_back(pat(daddr));
  endtask

  // Core loads every cycle while DMA reads 0x40 continuously; phase within a
  // 12-cycle round: 8 blocked cycles, then 4 stalled DMA beats
  task automatic contend(input int n, input string nm);
    logic g;
    for (int k = 0; k < n; k++) begin
      g = ((k % 12) >= 8);
      step(1'b0, 1'b0, 1'b1, 4'hF, 32'h200 + 32'(4 * k), 32'h0, 1'b1, 1'b0,
           32'h40, 32'h0, g, g, nm);
    end
  endtask

  task automatic idle(input string nm);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, nm);
  endtask

  task automatic do_reset(input string nm);
    step(1'b1, 1'b0, 1'b1, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, nm);
  endtask

  typedef struct {
    logic cwe, cre, dreq, dwr, eg, es;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // core load
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // core store
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // DMA read, core idle
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // DMA write, core idle
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // core store beats DMA
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // core load beats DMA
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // DMA write granted

    rst = 1'b1; c_we = 1'b0; c_re = 1'b0; c_bs = 4'h0; c_addr = 32'h0; c_wd = 32'h0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 32'h0; d_wd = 32'h0;

    // Reset forces grant/stall/enables low even with requests pending
    do_reset("rst0");
    do_reset("rst1");

    // Table-driven basic arbitration
    for (int i = 0; i < 8; i++)
      step(1'b0, tbl[i].cwe, tbl[i].cre, 4'h5, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i),
           tbl[i].dreq, tbl[i].dwr, (tbl[i].dwr ? 32'h80 : 32'h40), 32'hD000_0000 + 32'(i),
           tbl[i].eg, tbl[i].es, $sformatf("tbl%0d", i));
    idle("tbl_end");

    // Core-only stream of 10 loads
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b1, 4'(i + 1), 32'h100 + 32'(4 * i), 32'h0, 1'b0, 1'b0,
           32'h0, 32'h0, 1'b0, 1'b0, "core_only");

    // Single DMA read at 0x40, then Rvalid pulse, then low
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, "dma_rd");
    idle("dma_rd_ret");
    idle("dma_rd_after");

    // Starvation escalation, 2 full rounds, then perf counters
    do_reset("rst_perf");
    contend(24, "contend");
    idle("contend_end");
`ifdef CP_DMEM_ARB_PERF_EN
    chk("perf_stall", perf_stall, 32'd8);
    chk("perf_beats", perf_beats, 32'd8);
`else
    chk("perf_stall", perf_stall, 32'd0);
    chk("perf_beats", perf_beats, 32'd0);
`endif

    // DMA drops request after 2 beats; next round must start from a zero wait count
    do_reset("rst_drop");
    contend(10, "drop_pre");
    step(1'b0, 1'b0, 1'b1, 4'hF, 32'h280, 32'h0, 1'b0, 1'b0, 32'h40, 32'h0,
         1'b0, 1'b0, "drop");
    contend(12, "drop_post");
    idle("drop_end");

    // Reset in the middle of a DMA read burst, after beat 2
    do_reset("rst_mid0");
    contend(10, "mid_pre");
    do_reset("rst_mid");
    contend(12, "mid_post");
    idle("mid_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp_dmem_arbiter.md
Name: cp_dmem_arbiter

Overview:
- Shares the CP data memory port between the CP load/store path (AGU outputs) and a DMA/host port.
- Core has default priority. A starvation counter escalates DMA to a bounded-length priority burst, during which the core is stalled.
- Sits between the CP AGU/EX stage and the DMEM macro, and routes the 1-cycle-latency read data back to the owner.

Parameters:
- DATA_WIDTH, 32: data bus width; byte-select width = DATA_WIDTH/8.
- ADDR_WIDTH, 32: address width.
- MAX_WAIT, 8: consecutive blocked DMA cycles before escalation; legal range 1..255.
- BURST_LEN, 4: maximum accepted DMA beats per escalated burst; legal range 1..255.

Ports:
- iClk  in  1  system clock, posedge.
- iReset  in  1  synchronous reset, active-high.
- iCore_Write_Enable  in  1  core store request.
- iCore_Read_Enable  in  1  core load request.
- iCore_Byte_Select  in  DATA_WIDTH/8  core byte lanes.
- iCore_Address  in  ADDR_WIDTH  core address.
- iCore_Store_Data  in  DATA_WIDTH  core store data (already lane-aligned).
- oCore_Stall  out  1  core request not serviced this cycle; core holds request.
- oCore_Load_Data  out  DATA_WIDTH  load data for core.
- iDMA_Req  in  1  DMA beat request; held until granted.
- iDMA_Write  in  1  1 = write, 0 = read.
- iDMA_Address  in  ADDR_WIDTH  DMA word address.
- iDMA_Store_Data  in  DATA_WIDTH  DMA write data (full word).
- oDMA_Grant  out  1  beat accepted this cycle.
- oDMA_Rvalid  out  1  oDMA_Rdata valid.
- oDMA_Rdata  out  DATA_WIDTH  DMA read data.
- oDMEM_Write_Enable  out  1  to DMEM.
- oDMEM_Read_Enable  out  1  to DMEM.
- oDMEM_Byte_Select  out  DATA_WIDTH/8  to DMEM.
- oDMEM_Address  out  ADDR_WIDTH  to DMEM.
- oDMEM_Store_Data  out  DATA_WIDTH  to DMEM.
- iDMEM_Load_Data  in  DATA_WIDTH  DMEM read data, valid the cycle after a read.
- oPerf_Stall_Count  out  32  see Optional Feature.
- oPerf_DMA_Beats  out  32  see Optional Feature.

Behaviour:
- Clocking/reset: one clock; iReset is synchronous, active-high.
- Reset values: state S_CORE; wait counter 0; beat counter 0; read-owner flag 0; oDMA_Rvalid 0.
- While iReset is high, all combinational outputs are forced 0: grants, stall, and DMEM enables.
- Core request (creq) = iCore_Write_Enable | iCore_Read_Enable.
- State S_CORE:
  - creq: core drives DMEM; oDMA_Grant = 0; oCore_Stall = 0.
  - !creq & iDMA_Req: DMA drives DMEM; oDMA_Grant = 1.
- Wait counter (S_CORE only):
  - +1 each cycle iDMA_Req & !oDMA_Grant.
  - Cleared on grant or on !iDMA_Req.
  - When the counter equals MAX_WAIT-1 and the DMA is blocked again, next state is S_DMA and the counter clears.
- State S_DMA:
  - iDMA_Req: DMA drives DMEM; oDMA_Grant = 1; oCore_Stall = creq.
  - !iDMA_Req: core is served as in S_CORE.
  - Beat counter +1 per grant.
  - Exit to S_CORE the cycle after the BURST_LEN-th grant, or the cycle after iDMA_Req is low. Beat counter clears on exit.
- DMA beat encoding: byte select all ones; write enable = iDMA_Write; read enable = !iDMA_Write.
- Idle (no grant to either side): DMEM enables 0. Address, data and byte select are driven from the core inputs.
- Read return:
  - Registered flag records whether the previous cycle's DMEM read belonged to DMA.
  - oDMA_Rvalid is a 1-cycle registered pulse: 1 the cycle after a granted DMA read.
  - oDMA_Rdata = iDMEM_Load_Data.
  - oCore_Load_Data = iDMEM_Load_Data, unconditionally. The core pipeline qualifies it.
- A core store and a DMA request in the same cycle in S_CORE: core wins; DMA waits.
- Reset during a burst: returns to S_CORE; no oDMA_Rvalid is produced for a read issued in the reset cycle.
- Address passthrough: no arithmetic or width conversion.

Optional Feature:
- Macro CP_DMEM_ARB_PERF_EN.
- Defined:
  - oPerf_Stall_Count counts cycles with oCore_Stall = 1.
  - oPerf_DMA_Beats counts oDMA_Grant cycles.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are present and tied to 0; no counter flops.

Test Plan:
- Core-only stream of 10 loads, DMA idle -> oCore_Stall never 1; DMEM mirrors core address/byte select each cycle.
- DMA read at 0x40, core idle -> oDMA_Grant in the same cycle; oDMA_Rvalid = 1 next cycle with DMEM data at 0x40; Rvalid low afterwards.
- Core requests every cycle and DMA requests continuously, MAX_WAIT=8, BURST_LEN=4 -> DMA blocked 8 cycles, then 4 grants with oCore_Stall = 1 for exactly those 4 cycles, then core resumes; pattern repeats.
- In S_DMA, DMA drops its request after 2 beats -> S_CORE next cycle; core stall total is 2 cycles; wait counter is 0.
- iReset asserted mid-burst after beat 2 of a DMA read burst -> all outputs 0 that cycle; S_CORE afterwards; no Rvalid for the reset-cycle read.
- With CP_DMEM_ARB_PERF_EN, run the 3rd scenario for 2 full rounds -> oPerf_Stall_Count = 8, oPerf_DMA_Beats = 8. Without the macro -> both 0.
